bus_demux2: RTL and testbench
=============================

// Module: bus_demux2
// PURPOSE
//  Fans one core load/store request channel out to two targets: data RAM (t0) and MMIO (t1).
//  Decodes the address and forwards the request with a valid/ready handshake.
//  Returns target responses to the core in order, registered; unmapped addresses get a local error response.
//  Sits between the RV32I LSU and the data-side memories; it is the 1:N counterpart of the 2:1 datapath select.
// PARAMETERS
//  RAM_BASE   32'h0000_0000  t0 window base
//  RAM_SIZE   32'h0001_0000  t0 window size in bytes (power of 2)
//  MMIO_BASE  32'h1000_0000  t1 window base
//  MMIO_SIZE  32'h0000_1000  t1 window size in bytes (power of 2)
//  MAX_OUT    2              max outstanding requests (1..7)
// PORTS
//  clk          in   1   single clock, rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  req_valid    in   1   core request valid
//  req_ready    out  1   core request accepted when valid&ready
//  req_addr     in   32  byte address
//  req_we       in   1   1=store, 0=load
//  req_wdata    in   32  store data
//  req_wstrb    in   4   byte enables
//  t0_/t1_req_valid  out 1; t0_/t1_req_ready in 1; t0_/t1_req_addr/we/wdata/wstrb out 32/1/32/4 (broadcast)
//  t0_/t1_rsp_valid  in  1   target response valid (no backpressure)
//  t0_/t1_rsp_rdata  in  32  target read data
//  rsp_valid    out  1   core response valid (core always accepts)
//  rsp_rdata    out  32  read data (0 for stores and errors)
//  rsp_err      out  1   1 = decode error
//  spurious     out  1   sticky: target response arrived while not expected
// BEHAVIOUR
//  - Decode (comb): addr in [RAM_BASE,+RAM_SIZE) -> RAM; in [MMIO_BASE,+MMIO_SIZE) -> MMIO; else ERR.
//  - State: cur_tgt (tgt_e), cnt (0..MAX_OUT outstanding). cnt==0 is IDLE; cnt>0 is ACTIVE on cur_tgt.
//  - stall = (cnt!=0 && sel!=cur_tgt) || (cnt==MAX_OUT). Different targets are never outstanding together,
//    so responses are in order without reorder storage.
//  - tN_req_valid = req_valid & sel==N & !stall; req_ready = !stall & (sel==RAM ? t0_ready : sel==MMIO ? t1_ready : 1).
//  - Accept (valid&ready): cnt++, cur_tgt<=sel. A response from cur_tgt in the same cycle: cnt unchanged.
//  - Target response: accepted only if cnt>0 and it comes from cur_tgt; cnt--. Registered to core:
//    rsp_valid/rsp_rdata asserted exactly 1 cycle after tN_rsp_valid, rsp_err=0.
//  - ERR target: while cur_tgt==ERR and cnt>0, one error response per cycle, starting the cycle after accept.
//    Outputs rsp_valid=1, rsp_err=1, rsp_rdata=0; cnt--. An accept in the same cycle keeps the stream gapless.
//  - Unexpected response (cnt==0 or wrong target): dropped, not forwarded, cnt unchanged; spurious<=1 until reset.
//  - Both targets respond in the same cycle: the cur_tgt one is taken, the other one sets spurious.
//  - Reset (any time, async): cnt=0, cur_tgt=RAM, rsp_valid=0, rsp_rdata=0, rsp_err=0, spurious=0.
//    Comb outputs follow: req_ready reflects t0/t1 ready; tN_req_valid only with req_valid.
//    In-flight transactions are abandoned; late target responses after reset set spurious.
//  - No combinational path from tN_rsp_* to the core rsp_* outputs.
// STRUCTURE
//  - bus_pkg: typedef enum logic [1:0] {TGT_RAM, TGT_MMIO, TGT_ERR} tgt_e; request/response structs.
//    The window-hit function in_window(addr, base, size) also goes in bus_pkg.
//  - Sub-module bus_addr_decode (comb addr -> tgt_e), reused by the future instruction-side demux.
//  - Top: counter, cur_tgt register, stall logic, registered response mux.
// TESTING
//  1 Load 0x0000_0010 (t0 ready=1), t0_rsp next cycle with 0xDEADBEEF
//    -> t0_req_valid 1 cycle; rsp_valid with 0xDEADBEEF, err=0, 1 cycle after t0_rsp.
//  2 Store 0x1000_0004 while t1_ready=0 for 3 cycles
//    -> req_ready=0 for 3 cycles, accept on cycle 4; later t1_rsp -> rsp_valid, rsp_rdata=0.
//  3 Two back-to-back RAM loads (MAX_OUT=2), then a third request
//    -> third stalls until the first response; responses return in order.
//  4 RAM load outstanding, then MMIO request -> req_ready=0 until the RAM response; then MMIO accepted.
//  5 Load 0x2000_0000 (unmapped) on 2 consecutive cycles
//    -> rsp_valid, err=1, rdata=0 on the following 2 consecutive cycles; no tN_req_valid.
//  6 t1_rsp_valid with cnt==0 -> no rsp_valid, spurious=1; assert rst_n=0 mid-burst
//    -> cnt=0, all rsp outputs 0 immediately.

Source files
------------

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared target enum, request/response structs and window decode helper
package bus_pkg;

    typedef enum logic [1:0] {
        TGT_RAM  = 2'd0,
        TGT_MMIO = 2'd1,
        TGT_ERR  = 2'd2
    } tgt_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bus_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } bus_rsp_t;

    // Subtraction form avoids overflow when base+size wraps past 2^32.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] size);
        return (addr >= base) && ((addr - base) < size);
    endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// rtl/bus_addr_decode.sv - combinational address to target decode
module bus_addr_decode
    import bus_pkg::*;
#(
    parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
    parameter logic [31:0] RAM_SIZE  = 32'h0001_0000,
    parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
    parameter logic [31:0] MMIO_SIZE = 32'h0000_1000
) (
    input  logic [31:0] addr,
    output tgt_e        tgt
);

    always_comb begin
        tgt = TGT_ERR;
        if (in_window(addr, RAM_BASE, RAM_SIZE)) begin
            tgt = TGT_RAM;
        end else if (in_window(addr, MMIO_BASE, MMIO_SIZE)) begin
            tgt = TGT_MMIO;
        end
    end

endmodule

// File: rtl/bus_demux2.sv
// rtl/bus_demux2.sv - 1:2 load/store demux with in-order registered responses and local decode errors
module bus_demux2
    import bus_pkg::*;
#(
    parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
    parameter logic [31:0] RAM_SIZE  = 32'h0001_0000,
    parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
    parameter logic [31:0] MMIO_SIZE = 32'h0000_1000,
    parameter int unsigned MAX_OUT   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        t0_req_valid,
    input  logic        t0_req_ready,
    output logic [31:0] t0_req_addr,
    output logic        t0_req_we,
    output logic [31:0] t0_req_wdata,
    output logic [3:0]  t0_req_wstrb,
    input  logic        t0_rsp_valid,
    input  logic [31:0] t0_rsp_rdata,
    output logic        t1_req_valid,
    input  logic        t1_req_ready,
    output logic [31:0] t1_req_addr,
    output logic        t1_req_we,
    output logic [31:0] t1_req_wdata,
    output logic [3:0]  t1_req_wstrb,
    input  logic        t1_rsp_valid,
    input  logic [31:0] t1_rsp_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        spurious
);

    localparam logic [2:0] CNT_MAX = 3'(MAX_OUT);

    tgt_e       sel;
    tgt_e       cur_tgt;
    logic [2:0] cnt;
    logic [2:0] cnt_n;
    logic [2:0] push_idx;
    logic [7:0] we_q;
    logic [7:0] we_n;
    logic       stall;
    logic       accept;
    logic       t0_hit;
    logic       t1_hit;
    logic       err_hit;
    logic       pop;
    logic       spur_evt;
    bus_req_t   req;
    bus_rsp_t   rsp_q;
    bus_rsp_t   rsp_n;

    bus_addr_decode #(
        .RAM_BASE (RAM_BASE),
        .RAM_SIZE (RAM_SIZE),
        .MMIO_BASE(MMIO_BASE),
        .MMIO_SIZE(MMIO_SIZE)
    ) u_decode (
        .addr(req_addr),
        .tgt (sel)
    );

    assign req = '{addr: req_addr, we: req_we, wdata: req_wdata, wstrb: req_wstrb};

    assign t0_req_addr  = req.addr;
    assign t0_req_we    = req.we;
    assign t0_req_wdata = req.wdata;
    assign t0_req_wstrb = req.wstrb;
    assign t1_req_addr  = req.addr;
    assign t1_req_we    = req.we;
    assign t1_req_wdata = req.wdata;
    assign t1_req_wstrb = req.wstrb;

    // Only one target may own outstanding requests, so responses can't reorder.
    assign stall        = ((cnt != 3'd0) && (sel != cur_tgt)) || (cnt == CNT_MAX);
    assign t0_req_valid = req_valid && (sel == TGT_RAM)  && !stall;
    assign t1_req_valid = req_valid && (sel == TGT_MMIO) && !stall;
    assign req_ready    = !stall && ((sel == TGT_RAM)  ? t0_req_ready :
                                     (sel == TGT_MMIO) ? t1_req_ready : 1'b1);
    assign accept       = req_valid && req_ready;

    assign t0_hit   = t0_rsp_valid && (cnt != 3'd0) && (cur_tgt == TGT_RAM);
    assign t1_hit   = t1_rsp_valid && (cnt != 3'd0) && (cur_tgt == TGT_MMIO);
    assign err_hit  = (cnt != 3'd0) && (cur_tgt == TGT_ERR);
    assign pop      = t0_hit || t1_hit || err_hit;
    assign spur_evt = (t0_rsp_valid && !t0_hit) || (t1_rsp_valid && !t1_hit);

    assign cnt_n    = cnt + {2'b00, accept} - {2'b00, pop};
    assign push_idx = cnt - {2'b00, pop};

    // In-order store flags so store responses return zero read data.
    always_comb begin
        we_n = pop ? {1'b0, we_q[7:1]} : we_q;
        if (accept) begin
            we_n[push_idx] = req_we;
        end
    end

    always_comb begin
        rsp_n = '0;
        rsp_n.err = err_hit;
        if (t0_hit && !we_q[0]) begin
            rsp_n.rdata = t0_rsp_rdata;
        end else if (t1_hit && !we_q[0]) begin
            rsp_n.rdata = t1_rsp_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 3'd0;
            cur_tgt   <= TGT_RAM;
            we_q      <= 8'd0;
            rsp_valid <= 1'b0;
            rsp_q     <= '0;
            spurious  <= 1'b0;
        end else begin
            cnt       <= cnt_n;
            we_q      <= we_n;
            rsp_valid <= pop;
            rsp_q     <= rsp_n;
            if (accept) begin
                cur_tgt <= sel;
            end
            if (spur_evt) begin
                spurious <= 1'b1;
            end
        end
    end

    assign rsp_rdata = rsp_q.rdata;
    assign rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_bus_demux2.sv
// tb/tb_bus_demux2.sv - decode vector table plus scoreboarded handshake sequences for bus_demux2
module tb_bus_demux2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        t0_req_valid, t0_req_ready, t0_req_we, t0_rsp_valid;
    logic [31:0] t0_req_addr, t0_req_wdata, t0_rsp_rdata;
    logic [3:0]  t0_req_wstrb;
    logic        t1_req_valid, t1_req_ready, t1_req_we, t1_rsp_valid;
    logic [31:0] t1_req_addr, t1_req_wdata, t1_rsp_rdata;
    logic [3:0]  t1_req_wstrb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        spurious;

    always #5 clk = ~clk;

    bus_demux2 dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .t0_req_valid(t0_req_valid), .t0_req_ready(t0_req_ready), .t0_req_addr(t0_req_addr),
        .t0_req_we(t0_req_we), .t0_req_wdata(t0_req_wdata), .t0_req_wstrb(t0_req_wstrb),
        .t0_rsp_valid(t0_rsp_valid), .t0_rsp_rdata(t0_rsp_rdata),
        .t1_req_valid(t1_req_valid), .t1_req_ready(t1_req_ready), .t1_req_addr(t1_req_addr),
        .t1_req_we(t1_req_we), .t1_req_wdata(t1_req_wdata), .t1_req_wstrb(t1_req_wstrb),
        .t1_rsp_valid(t1_rsp_valid), .t1_rsp_rdata(t1_rsp_rdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .spurious(spurious)
    );

    typedef struct {
        logic [31:0] addr;
        logic        t0r;
        logic        t1r;
        logic        exp_ready;
        logic        exp_t0v;
        logic        exp_t1v;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt = 0;
    int   total    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push_exp(input logic [31:0] rdata, input logic err);
        exp_t e;
        e.rdata = rdata;
        e.err   = err;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_rdata", rsp_rdata, e.rdata);
                check("sb_err", {31'd0, rsp_err}, {31'd0, e.err});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        vecs[0] = '{32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{32'h0000_FFFC, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{32'h0000_FFFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{32'h0001_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{32'h0FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{32'h1000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{32'h1000_0FFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{32'h1000_1000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{32'h2000_0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0; req_valid = 1'b0; req_addr = 32'd0; req_we = 1'b0;
        req_wdata = 32'd0; req_wstrb = 4'hF;
        t0_req_ready = 1'b1; t1_req_ready = 1'b1;
        t0_rsp_valid = 1'b0; t0_rsp_rdata = 32'd0;
        t1_rsp_valid = 1'b0; t1_rsp_rdata = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_spurious", {31'd0, spurious}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_t0_valid", {31'd0, t0_req_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Decode table, idle state, valid dropped before the edge so nothing is accepted
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req_addr = vecs[i].addr; t0_req_ready = vecs[i].t0r; t1_req_ready = vecs[i].t1r;
            req_valid = 1'b1;
            #1;
            check($sformatf("vec%0d_ready", i), {31'd0, req_ready}, {31'd0, vecs[i].exp_ready});
            check($sformatf("vec%0d_t0v", i), {31'd0, t0_req_valid}, {31'd0, vecs[i].exp_t0v});
            check($sformatf("vec%0d_t1v", i), {31'd0, t1_req_valid}, {31'd0, vecs[i].exp_t1v});
            check($sformatf("vec%0d_addr", i), t0_req_addr, vecs[i].addr);
            #1 req_valid = 1'b0;
        end
        t0_req_ready = 1'b1; t1_req_ready = 1'b1;

        // 1: single RAM load
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_0010; req_we = 1'b0;
        #1 check("t1_ld_t0v", {31'd0, t0_req_valid}, 32'd1);
        push_exp(32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        req_valid = 1'b0; t0_rsp_valid = 1'b1; t0_rsp_rdata = 32'hDEAD_BEEF;
        #1 check("t1_ld_t0v_drop", {31'd0, t0_req_valid}, 32'd0);
        check("t1_rsp_not_yet", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        t0_rsp_valid = 1'b0;
        #1 check("t1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        @(negedge clk);
        #1 check("t1_rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);

        // 2: MMIO store with target backpressure
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h1000_0004; req_we = 1'b1; req_wdata = 32'h1234_5678;
        t1_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("t2_stall%0d", i), {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        t1_req_ready = 1'b1;
        #1 check("t2_accept", {31'd0, req_ready}, 32'd1);
        check("t2_wdata", t1_req_wdata, 32'h1234_5678);
        push_exp(32'd0, 1'b0);
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0;
        t1_rsp_valid = 1'b1; t1_rsp_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        t1_rsp_valid = 1'b0;
        #1 check("t2_rsp_valid", {31'd0, rsp_valid}, 32'd1);

        // 3: two outstanding RAM loads, third waits for first response
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_0100;
        push_exp(32'hA000_0001, 1'b0);
        @(negedge clk);
        req_addr = 32'h0000_0104;
        push_exp(32'hB000_0002, 1'b0);
        @(negedge clk);
        req_addr = 32'h0000_0108;
        #1 check("t3_full_stall", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        t0_rsp_valid = 1'b1; t0_rsp_rdata = 32'hA000_0001;
        #1 check("t3_stall_rsp_cycle", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        t0_rsp_rdata = 32'hB000_0002;
        #1 check("t3_third_accept", {31'd0, req_ready}, 32'd1);
        push_exp(32'hC000_0003, 1'b0);
        @(negedge clk);
        req_valid = 1'b0; t0_rsp_rdata = 32'hC000_0003;
        @(negedge clk);
        t0_rsp_valid = 1'b0;
        @(negedge clk);

        // 4: MMIO request blocked by outstanding RAM load
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_0200;
        push_exp(32'hD000_0004, 1'b0);
        @(negedge clk);
        req_addr = 32'h1000_0008;
        #1 check("t4_cross_stall", {31'd0, req_ready}, 32'd0);
        check("t4_t1v_blocked", {31'd0, t1_req_valid}, 32'd0);
        @(negedge clk);
        t0_rsp_valid = 1'b1; t0_rsp_rdata = 32'hD000_0004;
        #1 check("t4_stall_rsp_cycle", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        t0_rsp_valid = 1'b0;
        #1 check("t4_mmio_accept", {31'd0, req_ready}, 32'd1);
        check("t4_t1v", {31'd0, t1_req_valid}, 32'd1);
        push_exp(32'hE000_0005, 1'b0);
        @(negedge clk);
        req_valid = 1'b0; t1_rsp_valid = 1'b1; t1_rsp_rdata = 32'hE000_0005;
        @(negedge clk);
        t1_rsp_valid = 1'b0;
        @(negedge clk);

        // 5: two unmapped loads back-to-back give a gapless error stream
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h2000_0000;
        #1 check("t5_ready0", {31'd0, req_ready}, 32'd1);
        check("t5_no_tv", {30'd0, t0_req_valid, t1_req_valid}, 32'd0);
        push_exp(32'd0, 1'b1);
        @(negedge clk);
        #1 check("t5_ready1", {31'd0, req_ready}, 32'd1);
        push_exp(32'd0, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        #1 check("t5_err0", {30'd0, rsp_valid, rsp_err}, 32'd3);
        @(negedge clk);
        #1 check("t5_err1", {30'd0, rsp_valid, rsp_err}, 32'd3);
        @(negedge clk);
        #1 check("t5_err_done", {31'd0, rsp_valid}, 32'd0);

        // 6: spurious response, then reset mid-burst
        @(negedge clk);
        t1_rsp_valid = 1'b1; t1_rsp_rdata = 32'h5555_AAAA;
        @(negedge clk);
        t1_rsp_valid = 1'b0;
        #1 check("t6_no_rsp", {31'd0, rsp_valid}, 32'd0);
        check("t6_spurious", {31'd0, spurious}, 32'd1);
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_0300;
        push_exp(32'hF000_0006, 1'b0);
        @(negedge clk);
        req_addr = 32'h0000_0304;
        t0_rsp_valid = 1'b1; t0_rsp_rdata = 32'hF000_0006;
        @(negedge clk);
        req_valid = 1'b0; t0_rsp_valid = 1'b0;
        #1 check("t6_burst_rsp", {31'd0, rsp_valid}, 32'd1);
        #1 rst_n = 1'b0;
        #1 check("t6_rst_rsp", {rsp_rdata[31:3], rsp_valid, rsp_err, spurious}, 32'd0);
        check("t6_rst_rdata", rsp_rdata, 32'd0);
        check("t6_rst_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        t0_rsp_valid = 1'b1; t0_rsp_rdata = 32'h7777_0000;
        @(negedge clk);
        t0_rsp_valid = 1'b0;
        #1 check("t6_late_no_rsp", {31'd0, rsp_valid}, 32'd0);
        check("t6_late_spurious", {31'd0, spurious}, 32'd1);
        @(negedge clk);
        #1 check("t6_sb_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
